// File: rtl/min3_stream_ctrl_pkg.sv
// rtl/min3_stream_ctrl_pkg.sv - shared constants and state type for the sliding-minimum stream filter
package min3_stream_ctrl_pkg;

  localparam int DW_DEFAULT = 13;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/min3_stream_ctrl_min.sv
// rtl/min3_stream_ctrl_min.sv - three-input unsigned minimum, purely combinational
module min3_stream_ctrl_min
  import min3_stream_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] y
);

  logic [DW-1:0] ab;

  assign ab = (a < b) ? a : b;
  assign y  = (ab < c) ? ab : c;

endmodule

// File: rtl/min3_stream_ctrl.sv
// rtl/min3_stream_ctrl.sv - 3-tap sliding-minimum filter over a framed valid/ready sample stream
module min3_stream_ctrl
  import min3_stream_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy
);

  state_t        state, state_nxt;
  logic [DW-1:0] w_prev, w_cur;
  logic [DW-1:0] min_c, min_out;
  logic          out_free, accept, load_out, load_last;

  assign out_free = !m_valid || m_ready;
  // clr wins over any handshake in the same cycle, so the sample is not taken
  assign accept   = s_valid && s_ready && !clr;
  assign busy     = (state != ST_EMPTY) || m_valid;

  // In FLUSH the missing right neighbour is replaced by the current sample
  min3_stream_ctrl_min #(.DW(DW)) u_min (
    .a (w_prev),
    .b (w_cur),
    .c (min_c),
    .y (min_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, input ready and output-load decisions
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load_out  = 1'b0;
    load_last = 1'b0;
    min_c     = s_data;
    case (state)
      ST_EMPTY: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_nxt = s_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        s_ready = out_free;
        if (s_valid && out_free) begin
          load_out = 1'b1;
          if (s_last) begin
            state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        min_c = w_cur;
        if (out_free) begin
          load_out  = 1'b1;
          load_last = 1'b1;
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (clr) begin
      state_nxt = ST_EMPTY;
      load_out  = 1'b0;
      load_last = 1'b0;
    end
  end

  // Two-sample history window; the first sample of a frame fills both taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_prev <= '0;
      w_cur  <= '0;
    end else if (clr) begin
      w_prev <= '0;
      w_cur  <= '0;
    end else if (accept) begin
      w_prev <= (state == ST_EMPTY) ? s_data : w_cur;
      w_cur  <= s_data;
    end
  end

  // Output register; a new result may replace one being taken in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (clr) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load_out) begin
      m_valid <= 1'b1;
      m_data  <= min_out;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_min3_stream_ctrl.sv
// tb/tb_min3_stream_ctrl.sv - scoreboard bench for the sliding-minimum stream filter
module tb_min3_stream_ctrl;

  localparam int DW   = 13;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  min3_stream_ctrl #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rmode = 0;
  int last_acc_cyc = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] fbuf[$];
  logic [DW-1:0] fr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] min_of(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // out[i] = min(x[i-1], x[i], x[i+1]) with both ends replicated
  function automatic logic [DW-1:0] ref_out(input int i);
    int n;
    logic [DW-1:0] l, c, r;
    n = fbuf.size();
    l = fbuf[(i > 0) ? i - 1 : 0];
    c = fbuf[i];
    r = fbuf[(i + 1 < n) ? i + 1 : i];
    return min_of(min_of(l, c), r);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Downstream ready patterns
  initial begin
    int tog;
    tog = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          m_ready = (tog == 0);
          tog = (tog + 1) % 3;
        end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Reference model: watches accepted inputs and queues expected outputs
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || clr) begin
        fbuf.delete();
        exp_q.delete();
      end else begin
        if (m_valid && !m_ready && fbuf.size() > 0)
          chk("s_ready_during_stall", s_ready, 0);
        if (s_valid && s_ready) begin
          fbuf.push_back(s_data);
          if (fbuf.size() >= 2)
            exp_q.push_back({1'b0, ref_out(fbuf.size() - 2)});
          if (s_last) begin
            exp_q.push_back({1'b1, ref_out(fbuf.size() - 1)});
            last_acc_cyc = cyc;
            fbuf.delete();
          end
        end
      end
    end
  end

  // Monitor: compares every delivered output and output stability under stall
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || clr) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", m_valid, 1);
          chk("stall_data_held", m_data, prev_data);
          chk("stall_last_held", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", m_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e[DW-1:0]);
            chk("m_last", m_last, e[DW]);
            // last accepted on one edge, FLUSH result loaded on the next
            if (e[DW] && rmode == 0)
              chk("flush_latency", cyc - last_acc_cyc, 2);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic send_sample(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("input_accept_timeout", t, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input bit with_last, input int gap_max);
    for (int i = 0; i < fr.size(); i++) begin
      if (gap_max > 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, gap_max)) @(posedge clk);
        #1;
      end
      send_sample(fr[i], with_last && (i == fr.size() - 1));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", (t < 1000), 1);
    @(posedge clk);
    #1;
    chk("idle_s_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    rmode   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fr = '{13'd5, 13'd3, 13'd8, 13'd2, 13'd9};
    send_frame(1, 0);
    drain();

    fr = '{13'd7};
    send_frame(1, 0);
    drain();

    fr = '{13'd4, 13'd6};
    send_frame(1, 0);
    fr = '{13'd1, 13'd0};
    send_frame(1, 0);
    drain();

    rmode = 2;
    fr = '{13'd10, 13'd20, 13'd30, 13'd40};
    send_frame(1, 0);
    drain();
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;

    fr = '{13'd8191, 13'd0, 13'd8191};
    send_frame(1, 0);
    fr = '{13'd8191, 13'd8191};
    send_frame(1, 0);
    drain();

    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    fr = '{13'd100, 13'd50};
    send_frame(0, 0);
    chk("abort_pending_valid", m_valid, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_m_last", m_last, 0);
    chk("abort_busy", busy, 0);
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    fr = '{13'd9, 13'd9};
    send_frame(1, 0);
    drain();

    rmode = 1;
    for (int f = 0; f < 150; f++) begin
      int len;
      len = $urandom_range(1, 6);
      fr.delete();
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0: fr.push_back(13'd0);
          1: fr.push_back(MAXV[DW-1:0]);
          default: fr.push_back(DW'($urandom_range(0, MAXV)));
        endcase
      end
      send_frame(1, 2);
    end
    drain();

    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    fr = '{13'd300, 13'd200};
    send_frame(0, 0);
    chk("pre_reset_valid", m_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_s_ready", s_ready, 1);
    exp_q.delete();
    fbuf.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    fr = '{13'd12, 13'd11, 13'd13};
    send_frame(1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
